// File: rtl/call_pkg.sv
// rtl/call_pkg.sv - shared types and defaults for start/done call-interface blocks
package call_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_LEN_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALL,
        WAIT_LOW,
        WAIT_HIGH
    } call_state_e;

endpackage

// File: rtl/call_issuer.sv
// rtl/call_issuer.sv - issues one start/done call to a callee and pulses ack on completion
module call_issuer
    import call_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             call_start,
    output logic [WIDTH-1:0] call_a,
    output logic [WIDTH-1:0] call_b,
    input  logic [WIDTH-1:0] call_result,
    input  logic             call_done,
    output logic             ack,
    output logic [WIDTH-1:0] product
);

    call_state_e      state_q, state_d;
    logic             call_start_q, call_start_d;
    logic [WIDTH-1:0] call_a_q, call_a_d;
    logic [WIDTH-1:0] call_b_q, call_b_d;

    always_comb begin
        state_d      = state_q;
        call_start_d = 1'b0;
        call_a_d     = call_a_q;
        call_b_d     = call_b_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    call_a_d     = a;
                    call_b_d     = b;
                    call_start_d = 1'b1;
                    state_d      = CALL;
                end
            end
            CALL:      state_d = WAIT_LOW;
            // The callee may still show done from its previous call; wait for it to drop first.
            WAIT_LOW:  if (!call_done) state_d = WAIT_HIGH;
            WAIT_HIGH: if (call_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            call_start_q <= 1'b0;
            call_a_q     <= '0;
            call_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            call_start_q <= call_start_d;
            call_a_q     <= call_a_d;
            call_b_q     <= call_b_d;
        end
    end

    assign call_start = call_start_q;
    assign call_a     = call_a_q;
    assign call_b     = call_b_q;
    assign ack        = (state_q == WAIT_HIGH) && call_done;
    assign product    = call_result;

endmodule

// File: rtl/dot_product_caller.sv
// rtl/dot_product_caller.sv - dot product of a streamed operand-pair list via an external multiply callee
module dot_product_caller
    import call_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             in_ready,
    output logic             call_start,
    output logic [WIDTH-1:0] call_a,
    output logic [WIDTH-1:0] call_b,
    input  logic [WIDTH-1:0] call_result,
    input  logic             call_done,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    // CALL here covers the whole time the issuer owns the callee (its CALL and WAIT_* states).
    call_state_e      state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic             go;
    logic             ack;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] sum;

    assign go  = (state_q == FETCH) && in_valid;
    assign sum = acc_q + product;

    call_issuer #(.WIDTH(WIDTH)) u_issuer (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .a           (in_a),
        .b           (in_b),
        .call_start  (call_start),
        .call_a      (call_a),
        .call_b      (call_b),
        .call_result (call_result),
        .call_done   (call_done),
        .ack         (ack),
        .product     (product)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        result_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        acc_d   = '0;
                        cnt_d   = len;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: if (in_valid) state_d = CALL;
            CALL: begin
                if (ack) begin
                    acc_d = sum;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        result_d = sum;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign in_ready = (state_q == FETCH);
    assign busy     = (state_q != IDLE);
    assign result   = result_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dot_product_caller.sv
// tb/tb_dot_product_caller.sv - self-checking bench for dot_product_caller with a 3-stage multiply callee
module tb_dot_product_caller;

    localparam int WIDTH = 32;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_ready;
    logic             call_start;
    logic [WIDTH-1:0] call_a;
    logic [WIDTH-1:0] call_b;
    logic [WIDTH-1:0] call_result;
    logic             call_done;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;

    always #5 clk = ~clk;

    dot_product_caller #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_ready    (in_ready),
        .call_start  (call_start),
        .call_a      (call_a),
        .call_b      (call_b),
        .call_result (call_result),
        .call_done   (call_done),
        .result      (result),
        .done        (done),
        .busy        (busy)
    );

    // 3-stage callee: drops done the cycle after call_start, raises it three cycles after
    // call_start, then keeps it high (stale) until the next call.
    logic             cv1, cv2;
    logic [WIDTH-1:0] cprod;
    logic             cdone;
    always @(posedge clk) begin
        if (reset) begin
            cv1 <= 1'b0; cv2 <= 1'b0; cdone <= 1'b0; cprod <= '0;
        end else begin
            cv1 <= call_start;
            cv2 <= cv1;
            if (call_start) begin
                cdone <= 1'b0;
                cprod <= call_a * call_b;
            end else if (cv2) begin
                cdone <= 1'b1;
            end
        end
    end
    assign call_result = cprod;
    assign call_done   = cdone;

    typedef struct {
        logic [LEN_W-1:0] len;
        logic [WIDTH-1:0] a [4];
        logic [WIDTH-1:0] b [4];
        int               gap;
        logic [WIDTH-1:0] exp_result;
        int               exp_cyc;
        bit               poke_start;
    } vec_t;

    vec_t vecs [8];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic feed(input int vi, input int npairs);
        bit ok;
        for (int i = 0; i < npairs; i++) begin
            in_valid = 1'b0;
            repeat (vecs[vi].gap) @(negedge clk);
            in_valid = 1'b1;
            in_a = vecs[vi].a[i];
            in_b = vecs[vi].b[i];
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                if (in_ready) ok = 1'b1;
                @(negedge clk);
            end
            if (!ok) check("feed_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic watch(input int vi);
        int               calls = 0;
        int               idx = 0;
        int               k_done = -1;
        bit               irdy = 1'b0;
        bit               stable = 1'b1;
        bit               prev_flight = 1'b0;
        logic [WIDTH-1:0] prev_a = '0;
        logic [WIDTH-1:0] prev_b = '0;
        @(posedge clk);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                if (vecs[vi].len != 0) check("done_cleared", {31'd0, done}, 32'd0);
            end
            if (vecs[vi].poke_start && k == 5) begin start = 1'b1; len = 8'd7; end
            if (vecs[vi].poke_start && k == 6) start = 1'b0;
            if (in_ready) irdy = 1'b1;
            if (call_start) begin
                if (idx < 4) begin
                    check($sformatf("call_a[%0d]", idx), call_a, vecs[vi].a[idx]);
                    check($sformatf("call_b[%0d]", idx), call_b, vecs[vi].b[idx]);
                end
                idx++;
                calls++;
            end
            if (prev_flight && busy && !in_ready && (call_a !== prev_a || call_b !== prev_b)) stable = 1'b0;
            prev_flight = busy && !in_ready;
            prev_a = call_a;
            prev_b = call_b;
            if (done) begin
                k_done = k;
                break;
            end
            @(posedge clk);
        end
        check("completed", {31'd0, k_done != -1}, 32'd1);
        check("result", result, vecs[vi].exp_result);
        if (vecs[vi].exp_cyc >= 0) check("done_latency", k_done, vecs[vi].exp_cyc);
        check("call_count", calls, {24'd0, vecs[vi].len});
        check("in_ready_seen", {31'd0, irdy}, {31'd0, vecs[vi].len != 0});
        check("call_ab_stable", {31'd0, stable}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input int vi);
        @(negedge clk);
        start = 1'b1;
        len = vecs[vi].len;
        fork
            feed(vi, int'(vecs[vi].len));
            watch(vi);
        join
    endtask

    initial begin
        vecs[0] = '{len: 8'd3, a: '{1, 3, 5, 0}, b: '{2, 4, 6, 0}, gap: 0, exp_result: 32'd44, exp_cyc: 16, poke_start: 1'b1};
        vecs[1] = '{len: 8'd0, a: '{0, 0, 0, 0}, b: '{0, 0, 0, 0}, gap: 0, exp_result: 32'd0, exp_cyc: 1, poke_start: 1'b0};
        vecs[2] = '{len: 8'd2, a: '{7, 9, 0, 0}, b: '{8, 10, 0, 0}, gap: 4, exp_result: 32'd146, exp_cyc: -1, poke_start: 1'b0};
        vecs[3] = '{len: 8'd2, a: '{32'hFFFF_FFFF, 1, 0, 0}, b: '{1, 1, 0, 0}, gap: 0, exp_result: 32'd0, exp_cyc: 11, poke_start: 1'b0};
        vecs[4] = '{len: 8'd1, a: '{2, 0, 0, 0}, b: '{3, 0, 0, 0}, gap: 0, exp_result: 32'd6, exp_cyc: 6, poke_start: 1'b0};
        vecs[5] = '{len: 8'd1, a: '{4, 0, 0, 0}, b: '{5, 0, 0, 0}, gap: 0, exp_result: 32'd20, exp_cyc: 6, poke_start: 1'b0};
        vecs[6] = '{len: 8'd3, a: '{1, 2, 3, 0}, b: '{1, 2, 3, 0}, gap: 0, exp_result: 32'd0, exp_cyc: -1, poke_start: 1'b0};
        vecs[7] = '{len: 8'd1, a: '{3, 0, 0, 0}, b: '{3, 0, 0, 0}, gap: 0, exp_result: 32'd9, exp_cyc: 6, poke_start: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_call_start", {31'd0, call_start}, 32'd0);
        check("rst_call_a", call_a, 32'd0);
        check("rst_call_b", call_b, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) run_vec(v);

        // Reset while element 2 of 3 waits for the callee, then a fresh run.
        @(negedge clk);
        start = 1'b1;
        len = vecs[6].len;
        fork
            feed(6, 2);
            begin
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                repeat (8) @(negedge clk);
                check("pre_reset_busy", {31'd0, busy}, 32'd1);
                check("pre_reset_call_done", {31'd0, call_done}, 32'd0);
                reset = 1'b1;
                @(negedge clk);
                check("mid_reset_busy", {31'd0, busy}, 32'd0);
                check("mid_reset_done", {31'd0, done}, 32'd0);
                check("mid_reset_result", result, 32'd0);
                reset = 1'b0;
            end
        join
        run_vec(7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
